// File: rtl/sha512_pkg.sv
// Shared definitions for the SHA-512 core.
// Holds the sequencing state encoding, the block and round geometry, and the
// initial hash value loaded into the hash state when a new message starts.
package sha512_pkg;

    localparam int N_WORDS    = 16;
    localparam int N_ROUNDS   = 80;
    localparam int K_LAST_IDX = N_ROUNDS - 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_PRIME  = 3'd2,
        S_ROUND  = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [63:0] SHA512_IV [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

endpackage

// File: rtl/sha512_round_ctr.sv
// 7-bit round counter for the SHA-512 compression loop.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : force count to 0 (priority over enable)
//   i_en         : advance one round; wraps to 0 after the last round
//   o_cnt        : current round index 0..79
//   o_tc         : count is at the last round (79)
//   o_lt16       : count is within the message-word rounds (< 16)
module sha512_round_ctr
    import sha512_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [6:0] o_cnt,
    output logic       o_tc,
    output logic       o_lt16
);

    logic [6:0] r_cnt;
    logic       w_tc;

    assign w_tc = (r_cnt == 7'(K_LAST_IDX));

    // Wrapping at terminal count leaves the index at 0 between blocks.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_tc ? 7'd0 : r_cnt + 7'd1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_tc   = w_tc;
    assign o_lt16 = (r_cnt < 7'(N_WORDS));

endmodule

// File: rtl/sha512_round_ctrl.sv
// Sequencing controller for the SHA-512 core: loads 16 words per block, runs
// 80 rounds while stepping the round-constant register, updates the hash
// state per block and presents the digest through a valid/ready handshake.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start / busy             : begin a message (IDLE only) / not idle
//   word_valid / word_ready  : message word handshake (ready only in LOAD)
//   blk_last                 : final-block flag, sampled on the 16th beat
//   w_load_en, w_idx         : write strobe and index into W[0..15]
//   hash_init                : one-cycle pulse after start is accepted
//   ena_K_reg                : enable of the round-constant register
//   round_en, round_idx      : round t is performed this cycle
//   w_sel_msg                : round uses a loaded word rather than expansion
//   hash_update              : add working variables into hash state
//   digest_valid / digest_ready : digest handshake
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting the 16 words of a block
// PRIME  | one cycle stepping K so K[0] is present in round 0
// ROUND  | 80 compression rounds
// UPDATE | fold working variables into the hash state
// DONE   | digest valid, waiting for digest_ready
module sha512_round_ctrl
    import sha512_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    input  logic       word_valid,
    output logic       word_ready,
    input  logic       blk_last,
    output logic       w_load_en,
    output logic [3:0] w_idx,
    output logic       hash_init,
    output logic       ena_K_reg,
    output logic       round_en,
    output logic [6:0] round_idx,
    output logic       w_sel_msg,
    output logic       hash_update,
    output logic       digest_valid,
    input  logic       digest_ready
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_w_idx;
    logic       r_last;
    logic       r_hash_init;
    logic       w_round_tc;
    logic       w_round_lt16;
    logic       w_last_word;
    logic       w_start_acc;

    sha512_round_ctr u_round_ctr (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (r_state == S_PRIME),
        .i_en   (r_state == S_ROUND),
        .o_cnt  (round_idx),
        .o_tc   (w_round_tc),
        .o_lt16 (w_round_lt16)
    );

    assign w_last_word = (r_w_idx == 4'(N_WORDS - 1));
    assign w_start_acc = (r_state == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        busy         = 1'b1;
        word_ready   = 1'b0;
        ena_K_reg    = 1'b0;
        round_en     = 1'b0;
        hash_update  = 1'b0;
        digest_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                word_ready = 1'b1;
                if (word_valid && w_last_word) w_state_nxt = S_PRIME;
            end
            S_PRIME: begin
                ena_K_reg   = 1'b1;
                w_state_nxt = S_ROUND;
            end
            S_ROUND: begin
                round_en = 1'b1;
                // 79 steps here plus the one in PRIME bring K back to index 0.
                ena_K_reg = !w_round_tc;
                if (w_round_tc) w_state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                hash_update = 1'b1;
                w_state_nxt = r_last ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_load_en = word_valid & word_ready;
    assign w_sel_msg = round_en & w_round_lt16;

    // w_idx wraps from 15 to 0 on the last beat, so the next block starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_idx     <= '0;
            r_last      <= 1'b0;
            r_hash_init <= 1'b0;
        end else begin
            r_hash_init <= w_start_acc;
            if (w_start_acc || r_state == S_UPDATE) begin
                r_w_idx <= '0;
            end else if (w_load_en) begin
                r_w_idx <= r_w_idx + 4'd1;
            end
            if (w_load_en && w_last_word) begin
                r_last <= blk_last;
            end
        end
    end

    assign w_idx     = r_w_idx;
    assign hash_init = r_hash_init;

endmodule

// File: tb/tb_sha512_round_ctrl.sv
module tb_sha512_round_ctrl;

    localparam logic [63:0] K0  = 64'h428a2f98d728ae22;
    localparam logic [63:0] K79 = 64'h6c44198c4a475817;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       word_valid = 1'b0;
    logic       blk_last = 1'b0;
    logic       digest_ready = 1'b0;
    logic       busy, word_ready, w_load_en, hash_init, ena_K_reg;
    logic       round_en, w_sel_msg, hash_update, digest_valid;
    logic [3:0] w_idx;
    logic [6:0] round_idx;

    sha512_round_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .word_valid(word_valid), .word_ready(word_ready), .blk_last(blk_last),
        .w_load_en(w_load_en), .w_idx(w_idx), .hash_init(hash_init),
        .ena_K_reg(ena_K_reg), .round_en(round_en), .round_idx(round_idx),
        .w_sel_msg(w_sel_msg), .hash_update(hash_update),
        .digest_valid(digest_valid), .digest_ready(digest_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: a message timeline. m_post counts cycles since the
    // 16th word beat of a block (0 while loading words).
    bit m_busy = 0, m_done = 0, m_last = 0, m_hinit = 0;
    int m_words = 0, m_post = 0, m_blk = 0;
    // Round-constant register stand-in, stepped by the DUT's ena_K_reg.
    int k_cnt = 0, k_out = 0;
    bit s_ena = 0;

    typedef struct {
        bit rst, start, wv, dr;
        bit e_busy, e_ready, e_hinit, e_load;
        logic [3:0] e_widx;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] kval(input int i);
        if (i == 0) return K0;
        if (i == 79) return K79;
        return 64'd0;
    endfunction

    task automatic model_update();
        if (rst) begin
            m_busy = 0; m_done = 0; m_last = 0; m_hinit = 0;
            m_words = 0; m_post = 0; m_blk = 0;
            k_cnt = 0; k_out = 0;
        end else begin
            if (s_ena) begin
                k_out = k_cnt;
                k_cnt = (k_cnt + 1) % 80;
            end
            m_hinit = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_words = 0; m_post = 0; m_hinit = 1; m_blk = 0;
                end
            end else if (m_done) begin
                if (digest_ready) begin
                    m_busy = 0; m_done = 0;
                end
            end else if (m_post == 0) begin
                if (word_valid) begin
                    m_words++;
                    if (m_words == 16) begin
                        m_last = blk_last;
                        m_post = 1;
                    end
                end
            end else if (m_post < 82) begin
                m_post++;
            end else begin
                m_post = 0; m_words = 0; m_blk++;
                if (m_last) m_done = 1;
            end
        end
    endtask

    task automatic compare_all();
        bit e_ready, e_ren, e_ena;
        int e_ridx;
        e_ready = m_busy && !m_done && m_post == 0;
        e_ren   = m_post >= 2 && m_post <= 81;
        e_ridx  = e_ren ? m_post - 2 : 0;
        e_ena   = m_post >= 1 && m_post <= 80;
        chk("busy", 64'(busy), 64'(m_busy));
        chk("word_ready", 64'(word_ready), 64'(e_ready));
        chk("w_load_en", 64'(w_load_en), 64'(word_valid & e_ready));
        chk("w_idx", 64'(w_idx), 64'(m_words % 16));
        chk("hash_init", 64'(hash_init), 64'(m_hinit));
        chk("ena_K_reg", 64'(ena_K_reg), 64'(e_ena));
        chk("round_en", 64'(round_en), 64'(e_ren));
        chk("round_idx", 64'(round_idx), 64'(e_ridx));
        chk("w_sel_msg", 64'(w_sel_msg), 64'(e_ren && e_ridx < 16));
        chk("hash_update", 64'(hash_update), 64'(m_post == 82));
        chk("digest_valid", 64'(digest_valid), 64'(m_done));
        if (e_ren) begin
            chk("k_align", 64'(k_out), 64'(e_ridx));
            if (e_ridx == 0) chk("k_out_r0", kval(k_out), K0);
            if (e_ridx == 79) chk("k_out_r79", kval(k_out), K79);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        s_ena = ena_K_reg;
    endtask

    // Drives one message from start until digest_valid is first observed.
    task automatic run_msg(input int nblk, input int bub, input bit noise, input bit dr_rnd,
                           output int cyc, output int n_ena, output int n_upd,
                           output int n_init, output int n_load);
        int c;
        c = 0; n_ena = 0; n_upd = 0; n_init = 0; n_load = 0;
        do begin
            start = (c == 0) ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            case (bub)
                0: word_valid = 1'b1;
                1: word_valid = 1'(c % 2);
                default: word_valid = 1'($urandom_range(0, 1));
            endcase
            blk_last = (m_blk >= nblk - 1);
            if (noise && !(m_busy && !m_done && m_post == 0))
                blk_last = 1'($urandom_range(0, 1));
            if (dr_rnd) digest_ready = 1'($urandom_range(0, 1));
            step();
            c++;
            n_ena  += int'(ena_K_reg);
            n_upd  += int'(hash_update);
            n_init += int'(hash_init);
            n_load += int'(word_ready);
        end while (digest_valid !== 1'b1 && c < 1000);
        start = 1'b0;
        word_valid = 1'b0;
        cyc = c;
        chk("dv_seen", 64'(digest_valid), 64'd1);
    endtask

    task automatic finish_done(input bit rnd);
        int n;
        n = 0;
        start = 1'b0;
        while (digest_valid === 1'b1 && n < 100) begin
            digest_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        digest_ready = 1'b0;
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc, n_ena, n_upd, n_init, n_load, dv_cnt, n;
        logic [3:0] w_before;
        logic [6:0] r_before;

        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 4'd0};
        tbl[1] = '{0, 1, 0, 0, 1, 1, 1, 0, 4'd0};
        tbl[2] = '{0, 1, 1, 0, 1, 1, 0, 1, 4'd1};
        tbl[3] = '{0, 0, 0, 0, 1, 1, 0, 0, 4'd1};
        tbl[4] = '{0, 0, 1, 1, 1, 1, 0, 1, 4'd2};
        tbl[5] = '{1, 1, 1, 0, 0, 0, 0, 0, 4'd0};
        tbl[6] = '{0, 0, 1, 1, 0, 0, 0, 0, 4'd0};
        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst; start = tbl[i].start;
            word_valid = tbl[i].wv; digest_ready = tbl[i].dr;
            step();
            chk("tbl_busy", 64'(busy), 64'(tbl[i].e_busy));
            chk("tbl_ready", 64'(word_ready), 64'(tbl[i].e_ready));
            chk("tbl_hinit", 64'(hash_init), 64'(tbl[i].e_hinit));
            chk("tbl_load", 64'(w_load_en), 64'(tbl[i].e_load));
            chk("tbl_widx", 64'(w_idx), 64'(tbl[i].e_widx));
        end
        start = 0; word_valid = 0; digest_ready = 0; rst = 0;
        step();

        // One block, no bubbles.
        digest_ready = 1;
        run_msg(1, 0, 0, 0, cyc, n_ena, n_upd, n_init, n_load);
        chk("one_blk_dv_cycle", 64'(cyc), 64'd99);
        chk("one_blk_ena_cnt", 64'(n_ena), 64'd80);
        chk("one_blk_upd", 64'(n_upd), 64'd1);
        chk("one_blk_init", 64'(n_init), 64'd1);
        finish_done(0);

        // Two blocks.
        digest_ready = 1;
        run_msg(2, 0, 0, 0, cyc, n_ena, n_upd, n_init, n_load);
        chk("two_blk_dv_cycle", 64'(cyc), 64'd197);
        chk("two_blk_ena_cnt", 64'(n_ena), 64'd160);
        chk("two_blk_upd", 64'(n_upd), 64'd2);
        chk("two_blk_init", 64'(n_init), 64'd1);
        finish_done(0);

        // Alternating word bubbles.
        digest_ready = 1;
        run_msg(1, 1, 0, 0, cyc, n_ena, n_upd, n_init, n_load);
        chk("bubble_load_cycles", 64'(n_load), 64'd31);
        chk("bubble_dv_cycle", 64'(cyc), 64'd114);
        finish_done(0);

        // Digest backpressure with start pulses during DONE.
        digest_ready = 0;
        run_msg(1, 0, 0, 0, cyc, n_ena, n_upd, n_init, n_load);
        dv_cnt = 1;
        for (int i = 0; i < 10; i++) begin
            start = 1'(i % 2);
            digest_ready = 0;
            step();
            dv_cnt += int'(digest_valid);
        end
        chk("bp_dv_cycles", 64'(dv_cnt), 64'd11);
        start = 1; digest_ready = 1;
        step();
        chk("bp_start_on_handshake", 64'(busy), 64'd0);
        start = 0; digest_ready = 0;
        step();
        chk("bp_idle", 64'(busy), 64'd0);

        // Reset in the middle of the rounds, then a fresh message.
        start = 1; word_valid = 1; blk_last = 1; digest_ready = 1; n = 0;
        do begin
            step();
            start = 0;
            n++;
        end while (!(round_en === 1'b1 && round_idx == 7'd40) && n < 200);
        chk("reach_round40", 64'(round_idx), 64'd40);
        rst = 1;
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_round_idx", 64'(round_idx), 64'd0);
        chk("rst_ena", 64'(ena_K_reg), 64'd0);
        rst = 0;
        run_msg(1, 0, 0, 0, cyc, n_ena, n_upd, n_init, n_load);
        chk("post_rst_dv_cycle", 64'(cyc), 64'd99);
        chk("post_rst_ena_cnt", 64'(n_ena), 64'd80);
        finish_done(0);

        // Spurious start / word_valid during ROUND.
        start = 1; word_valid = 1; blk_last = 1; digest_ready = 0; n = 0;
        do begin
            step();
            start = 0;
            n++;
        end while (!(round_en === 1'b1 && round_idx == 7'd20) && n < 200);
        w_before = w_idx;
        r_before = round_idx;
        start = 1; word_valid = 1;
        step();
        chk("spur_w_idx", 64'(w_idx), 64'(w_before));
        chk("spur_round_idx", 64'(round_idx), 64'(r_before + 7'd1));
        chk("spur_load_en", 64'(w_load_en), 64'd0);
        start = 0; n = 0;
        while (digest_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("spur_dv_seen", 64'(digest_valid), 64'd1);
        finish_done(0);

        // Randomized messages.
        for (int r = 0; r < 8; r++) begin
            int nb;
            nb = int'($urandom_range(1, 3));
            run_msg(nb, 2, 1, 1, cyc, n_ena, n_upd, n_init, n_load);
            chk("rnd_upd", 64'(n_upd), 64'(nb));
            chk("rnd_init", 64'(n_init), 64'd1);
            chk("rnd_ena_cnt", 64'(n_ena), 64'(80 * nb));
            finish_done(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sha512_round_ctrl.md
# sha512_round_ctrl

Sequencing controller for the SHA-512 core. It accepts a message as a stream of 1024-bit blocks, each delivered as 16 64-bit words. For each block it runs the 80 compression rounds and drives the enable of the round-constant register `K_register_64bit`, so that `K_out` carries K[t] in round t. After the last block it presents the digest through a valid/ready handshake. It sits between the padding front-end and the round datapath (W schedule, working variables, hash state).

## Interface
- `N_WORDS`, 16: words per block; fixed, not overridable.
- `N_ROUNDS`, 80: rounds per block; must equal the K table depth of 80, fixed.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset. The top level drives the `K_register_64bit` reset from `~rst`, so both blocks reset together.
- `start`  in  1: begin a new message; accepted only in IDLE.
- `busy`  out  1: high in every state except IDLE.
- `word_valid`  in  1: message word present.
- `word_ready`  out  1: high only in LOAD.
- `blk_last`  in  1: sampled on the 16th word beat; 1 means this block is the final block.
- `w_load_en`  out  1: equals `word_valid & word_ready`; writes the word into W[w_idx].
- `w_idx`  out  4: index of the word being loaded, 0..15.
- `hash_init`  out  1: 1-cycle pulse on start acceptance; loads the SHA-512 IV into the hash state.
- `ena_K_reg`  out  1: drives the enable port of `K_register_64bit`.
- `round_en`  out  1: the datapath performs round `round_idx` this cycle.
- `round_idx`  out  7: current round, 0..79.
- `w_sel_msg`  out  1: `round_en & (round_idx < 16)`. Selects the loaded W word; otherwise the schedule-expanded word is used.
- `hash_update`  out  1: 1-cycle pulse; adds the working variables into the hash state.
- `digest_valid`  out  1: digest on the hash-state outputs is final.
- `digest_ready`  in  1: consumer accepts the digest.

## Operation
States: IDLE, LOAD, PRIME, ROUND, UPDATE, DONE.
- **IDLE**
  - When `start`=1: pulse `hash_init`, clear `w_idx`, go to LOAD.
- **LOAD**
  - `word_ready`=1. Each beat increments `w_idx`.
  - On the beat with `w_idx`=15: latch `blk_last`, go to PRIME.
  - Bubbles (`word_valid`=0) are allowed; the controller waits.
- **PRIME**
  - One cycle. `ena_K_reg`=1, so `K_out`=K[0] in the next cycle. `round_idx` is cleared.
  - Go to ROUND.
- **ROUND**
  - 80 cycles, `round_en`=1, `round_idx`=t with t = 0..79.
  - `ena_K_reg` = (t ≠ 79).
  - At t=79, go to UPDATE.
- **UPDATE**
  - One cycle, `hash_update`=1.
  - Next state is DONE if the latched `blk_last`=1; otherwise LOAD with `w_idx`=0.
- **DONE**
  - `digest_valid`=1 and held until `digest_ready`=1, then IDLE.
  - `start` is not accepted in the cycle the digest handshake completes.
- **K alignment invariant**
  - Exactly 80 `ena_K_reg` pulses per block: 1 in PRIME and 79 in ROUND.
  - The K register's internal counter therefore returns to 0 at every block boundary. No other state asserts `ena_K_reg`.

## Timing
- **Reset values** (all registers reset on a `rst`=1 clock edge):
  - state=IDLE.
  - `busy`, `word_ready`, `w_load_en`, `hash_init`, `ena_K_reg`, `round_en`, `w_sel_msg`, `hash_update`, `digest_valid` all 0.
  - `w_idx`=0, `round_idx`=0, latched last flag=0.
- **Per-block latency**
  - Minimum 98 cycles: 16 LOAD + 1 PRIME + 80 ROUND + 1 UPDATE.
  - Each LOAD bubble adds one cycle.
- **One-block message**: `start` at cycle 0 with `word_valid` held high gives `digest_valid` first high at cycle 99.
- **Round-constant timing**: `K_out`=K[t] in the same cycle as `round_en` with `round_idx`=t. This follows from the K register's one-cycle registered output.
- **Boundary conditions**
  - `start` while `busy`: ignored.
  - `word_valid` outside LOAD: ignored, since `word_ready`=0.
  - `digest_ready` high before DONE: ignored.
  - `digest_ready` already high on DONE entry: 1-cycle DONE.
  - `rst` mid-LOAD, mid-ROUND or mid-DONE: IDLE on the next edge with all outputs at reset values. The K register is reset by the same reset, so alignment is restored.
- All outputs are registered or decoded directly from state, with no combinational input-to-output paths. The one exception is `w_load_en`, which is combinational by definition.

## Structure
- Shared package `sha512_pkg`:
  - State enum.
  - `N_WORDS`, `N_ROUNDS`, `K_LAST_IDX`=79.
  - IV constants used by the hash-state block on `hash_init`.
- Sub-module `sha512_round_ctr`: 7-bit round counter with clear, enable, terminal-count (t=79) flag and `lt16` flag. Reusable by the W schedule.

## Test plan
- **One block, no bubbles**
  - Stimulus: `start`, 16 words with `blk_last`=1, `digest_ready`=1.
  - Required: `ena_K_reg` high for exactly 80 cycles; `K_out`=64'h428a2f98d728ae22 with `round_idx`=0 and 64'h6c44198c4a475817 with `round_idx`=79; `digest_valid` at cycle 99.
- **Two blocks**
  - Stimulus: `blk_last`=0, then `blk_last`=1.
  - Required: 2 `hash_update` pulses, 1 `hash_init`; K[0] again at the second block's `round_idx`=0; `digest_valid` at cycle 197.
- **Word bubbles**
  - Stimulus: `word_valid` toggling 1,0,1,0...
  - Required: `w_idx` advances only on beats; PRIME entered after 31 LOAD cycles.
- **Backpressure**
  - Stimulus: `digest_ready` held low 10 cycles in DONE.
  - Required: `digest_valid` stays 1 for 11 cycles; `start` pulses during DONE are ignored.
- **Reset mid-ROUND**
  - Stimulus: `rst` at `round_idx`=40, then a fresh one-block message.
  - Required: all outputs at reset values; K[0] at `round_idx`=0 of the new block.
- **Spurious inputs**
  - Stimulus: `start` during ROUND; `word_valid` during ROUND.
  - Required: no state or `w_idx` change; `w_load_en`=0.
